toggle_state_table: RTL and testbench
=====================================

# toggle_state_table

Parametrised multi-port ID toggle-bit table for tracking per-instruction-ID state parity in the issue/writeback path. It holds one bit per ID and supports several toggle ports and read ports per cycle. A same-cycle multi-toggle to one ID resolves by XOR. It also provides a handshaked, rate-limited bulk clear for flush, and maintains a registered population count of set bits.

## Interface
Parameters:
- DEPTH, MAX_IDS: number of entries; power of two, ≥ 2.
- NUM_TOGGLE_PORTS, 2: toggle write ports, ≥ 1.
- NUM_READ_PORTS, 3: read ports, ≥ 1.
- CLEAR_PER_CYCLE, 2: entries cleared per cycle during a sweep; power of two, divides DEPTH.
- ID_W, $clog2(DEPTH): derived; not to be overridden.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- toggle  in  [NUM_TOGGLE_PORTS]  per-port toggle request.
- toggle_id  in  [NUM_TOGGLE_PORTS][ID_W]  per-port target ID.
- toggle_ready  out  1  table accepting toggles this cycle.
- clear_req  in  1  bulk-clear request, sampled in IDLE.
- clear_busy  out  1  sweep in progress.
- clear_done  out  1  one-cycle pulse: sweep complete.
- read_id  in  [NUM_READ_PORTS][ID_W]  read addresses.
- read_data  out  [NUM_READ_PORTS]  bit for the matching read_id.
- set_count  out  $clog2(DEPTH+1)  registered count of set entries.

## Operation
- Storage: DEPTH flops, all 0 after reset.
- Toggle acceptance: a toggle is accepted only when toggle[p] && toggle_ready. Toggles seen while toggle_ready=0 are dropped with no effect. The producer holds the request.
- Per-entry update: entry[i] ^= XOR over ports p of (accepted[p] && toggle_id[p]==i). Two ports toggling the same ID in one cycle leave it unchanged. Three toggles flip it.
- set_count: next = count + rises − falls. Rises and falls are per-entry 0→1 and 1→0 transitions this cycle, computed on the full DEPTH vector. Width is sufficient for DEPTH with no wrap.
- FSM states IDLE, CLEAR, DONE:
  - IDLE: toggle_ready=1. A clear_req moves the FSM to CLEAR and resets sweep_ptr to 0. Toggles accepted in the same cycle as clear_req are still applied.
  - CLEAR: clear_busy=1 and toggle_ready=0. Entries sweep_ptr .. sweep_ptr+CLEAR_PER_CYCLE−1 are zeroed each cycle, and sweep_ptr advances. On the final group the FSM goes to DONE.
  - DONE: clear_done=1 for one cycle, toggle_ready=0, then the FSM returns to IDLE.
- clear_req in CLEAR or DONE is ignored and not queued.
- set_count during a sweep decrements by the number of set entries in the group cleared. It is 0 in DONE.
- Reads: read_data[r] = entry[read_id[r]]. Reads are combinational from stored state. Reads during CLEAR return 0 for swept entries and stored values for unswept ones.
- Reset mid-sweep: asynchronous. All entries go to 0, the FSM goes to IDLE, sweep_ptr goes to 0, and all outputs take their reset values immediately.

## Timing
- Reset values: toggle_ready=1, clear_busy=0, clear_done=0, set_count=0, read_data=0 for all ports.
- Toggle-to-read latency: 1 cycle, meaning visible after the next rising edge. The exception is under the bypass configuration below.
- Sweep length: clear_req accepted at edge N. Then clear_busy=1 for cycles N+1 .. N+DEPTH/CLEAR_PER_CYCLE. clear_done=1 in the following cycle. toggle_ready returns one cycle after that.
- set_count is updated on the same edge as the entries it counts.

## Configuration
- TOGGLE_STATE_TABLE_BYPASS_EN defined: read_data[r] = entry[read_id[r]] XOR (parity of this cycle's accepted toggles to read_id[r]). This is a same-cycle forward. It is inactive while toggle_ready=0.
- Macro undefined: reads see stored state only, with 1-cycle latency. Storage, FSM and set_count are identical in both builds.

## Test plan
- Reset then single toggles: toggle id 3 on port 0 → read_data=1 on id 3 the next cycle, set_count=1. Toggle id 3 again → 0, set_count=0.
- Same-cycle collision: ports 0 and 1 both toggle id 5 → id 5 stays 0 and set_count unchanged. Ports 0 and 1 toggle ids 2 and 6 → both 1, set_count=2.
- Bulk clear with DEPTH=8 and CLEAR_PER_CYCLE=2: set ids 0, 3, 7, then pulse clear_req → clear_busy high 4 cycles, then clear_done pulse. Id 0 reads 0 after cycle 1 while id 7 still reads 1. All entries are 0 and set_count=0 at DONE. Toggles during the sweep are dropped.
- clear_req with a simultaneous toggle of id 4 in IDLE → toggle applied, then cleared. A second clear_req during CLEAR → no extra sweep.
- Async reset asserted mid-sweep with entries 6 and 7 still set → all reads 0, set_count=0, toggle_ready=1 without waiting for a clock edge.
- With TOGGLE_STATE_TABLE_BYPASS_EN, toggling id 1 while reading id 1 returns 1 in the same cycle. Without the macro it returns 0 and then 1 on the next cycle.

Source files
------------

// File: rtl/toggle_state_table.sv
// toggle_state_table: multi-port per-ID toggle-bit table with XOR-merged toggles, rate-limited bulk clear and registered popcount.
// Optional same-cycle read forwarding of accepted toggles: define TOGGLE_STATE_TABLE_BYPASS_EN.
module toggle_state_table #(
  parameter int unsigned DEPTH            = 8,
  parameter int unsigned NUM_TOGGLE_PORTS = 2,
  parameter int unsigned NUM_READ_PORTS   = 3,
  parameter int unsigned CLEAR_PER_CYCLE  = 2,
  localparam int unsigned ID_W            = $clog2(DEPTH),
  localparam int unsigned CNT_W           = $clog2(DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_TOGGLE_PORTS-1:0]            toggle,
  input  logic [NUM_TOGGLE_PORTS-1:0][ID_W-1:0]  toggle_id,
  output logic                                   toggle_ready,
  input  logic                                   clear_req,
  output logic                                   clear_busy,
  output logic                                   clear_done,
  input  logic [NUM_READ_PORTS-1:0][ID_W-1:0]    read_id,
  output logic [NUM_READ_PORTS-1:0]              read_data,
  output logic [CNT_W-1:0]                       set_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned     GRP_SHIFT = $clog2(CLEAR_PER_CYCLE);
  localparam logic [ID_W-1:0] PTR_STEP  = ID_W'(CLEAR_PER_CYCLE);
  localparam logic [ID_W-1:0] LAST_PTR  = ID_W'(DEPTH - CLEAR_PER_CYCLE);

  logic [1:0]                  state_q, state_d;
  logic [ID_W-1:0]             sweep_ptr_q, sweep_ptr_d;
  logic [DEPTH-1:0]            entry_q, entry_d;
  logic [CNT_W-1:0]            set_count_q, set_count_d;
  logic [NUM_TOGGLE_PORTS-1:0] accepted;
  logic [DEPTH-1:0]            flip;
  logic [DEPTH-1:0]            sweep_mask;
  logic [CNT_W-1:0]            rises, falls;

  assign toggle_ready = (state_q == ST_IDLE);
  assign clear_busy   = (state_q == ST_CLEAR);
  assign clear_done   = (state_q == ST_DONE);
  assign set_count    = set_count_q;
  assign accepted     = toggle & {NUM_TOGGLE_PORTS{toggle_ready}};

  // Per-entry parity of accepted toggles: an even number of hits cancels out.
  always_comb begin
    flip = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned p = 0; p < NUM_TOGGLE_PORTS; p++) begin
        flip[i] = flip[i] ^ (accepted[p] && (toggle_id[p] == ID_W'(i)));
      end
    end
  end

  // sweep_ptr is always group-aligned, so group membership is a compare of the upper ID bits.
  always_comb begin
    sweep_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sweep_mask[i] = ((ID_W'(i) >> GRP_SHIFT) == (sweep_ptr_q >> GRP_SHIFT));
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_ptr_d = sweep_ptr_q;
    entry_d     = entry_q;
    case (state_q)
      ST_IDLE: begin
        entry_d = entry_q ^ flip;
        if (clear_req) begin
          state_d     = ST_CLEAR;
          sweep_ptr_d = '0;
        end
      end
      ST_CLEAR: begin
        entry_d     = entry_q & ~sweep_mask;
        sweep_ptr_d = sweep_ptr_q + PTR_STEP;
        if (sweep_ptr_q == LAST_PTR) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Modular add-then-subtract is exact because the true result never exceeds DEPTH.
  always_comb begin
    rises = '0;
    falls = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rises = rises + CNT_W'(~entry_q[i] & entry_d[i]);
      falls = falls + CNT_W'(entry_q[i] & ~entry_d[i]);
    end
    set_count_d = set_count_q + rises - falls;
  end

  always_comb begin
    read_data = '0;
    for (int unsigned r = 0; r < NUM_READ_PORTS; r++) begin
`ifdef TOGGLE_STATE_TABLE_BYPASS_EN
      read_data[r] = entry_q[read_id[r]] ^ flip[read_id[r]];
`else
      read_data[r] = entry_q[read_id[r]];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sweep_ptr_q <= '0;
      entry_q     <= '0;
      set_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
      entry_q     <= entry_d;
      set_count_q <= set_count_d;
    end
  end

endmodule

// File: tb/tb_toggle_state_table.sv
// Scoreboard bench for toggle_state_table: expectations queued with stimulus, compared after each edge.
`timescale 1ns/1ps
module tb_toggle_state_table;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NT    = 2;
  localparam int unsigned NR    = 3;
  localparam int unsigned CPC   = 2;
  localparam int unsigned ID_W  = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef TOGGLE_STATE_TABLE_BYPASS_EN
  localparam int unsigned BYP = 1;
`else
  localparam int unsigned BYP = 0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NT-1:0]            toggle;
  logic [NT-1:0][ID_W-1:0]  toggle_id;
  logic                     toggle_ready;
  logic                     clear_req;
  logic                     clear_busy;
  logic                     clear_done;
  logic [NR-1:0][ID_W-1:0]  read_id;
  logic [NR-1:0]            read_data;
  logic [CW-1:0]            set_count;

  int checks   = 0;
  int failures = 0;

  typedef enum int {K_RD, K_CNT, K_RDY, K_BUSY, K_DONE} kind_e;
  typedef struct {
    kind_e       kind;
    int unsigned port;
    int unsigned id;
    int unsigned exp;
  } item_t;

  item_t sb[$];
  string tags[$];

  toggle_state_table #(
    .DEPTH(DEPTH),
    .NUM_TOGGLE_PORTS(NT),
    .NUM_READ_PORTS(NR),
    .CLEAR_PER_CYCLE(CPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .toggle(toggle),
    .toggle_id(toggle_id),
    .toggle_ready(toggle_ready),
    .clear_req(clear_req),
    .clear_busy(clear_busy),
    .clear_done(clear_done),
    .read_id(read_id),
    .read_data(read_data),
    .set_count(set_count)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic exp_rd(input string tag, input int unsigned port, input int unsigned id,
                        input int unsigned val);
    item_t it;
    it.kind = K_RD; it.port = port; it.id = id; it.exp = val;
    sb.push_back(it);
    tags.push_back(tag);
  endtask

  task automatic exp_sig(input string tag, input kind_e kind, input int unsigned val);
    item_t it;
    it.kind = kind; it.port = 0; it.id = 0; it.exp = val;
    sb.push_back(it);
    tags.push_back(tag);
  endtask

  task automatic drain();
    item_t       it;
    string       tg;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      tg  = tags.pop_front();
      obs = '0;
      case (it.kind)
        K_RD: begin
          read_id[it.port] = ID_W'(it.id);
          #1;
          obs = 32'(read_data[it.port]);
        end
        K_CNT:  obs = 32'(set_count);
        K_RDY:  obs = 32'(toggle_ready);
        K_BUSY: obs = 32'(clear_busy);
        K_DONE: obs = 32'(clear_done);
        default: obs = '1;
      endcase
      check_eq(tg, obs, 32'(it.exp));
    end
  endtask

  task automatic tog(input int unsigned p, input int unsigned id);
    toggle[p]    = 1'b1;
    toggle_id[p] = ID_W'(id);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    toggle    = '0;
    clear_req = 1'b0;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    toggle    = '0;
    toggle_id = '0;
    clear_req = 1'b0;
    read_id   = '0;
    #5;
    exp_sig("rst_ready", K_RDY, 1);
    exp_sig("rst_busy", K_BUSY, 0);
    exp_sig("rst_done", K_DONE, 0);
    exp_sig("rst_count", K_CNT, 0);
    exp_rd("rst_rd0", 0, 0, 0);
    exp_rd("rst_rd1", 1, 3, 0);
    exp_rd("rst_rd2", 2, 7, 0);
    drain();
    @(negedge clk);
    rst = 1'b1;

    // single toggles
    tog(0, 3); exp_rd("tog3_on", 0, 3, 1); exp_sig("cnt_tog3_on", K_CNT, 1); tick();
    tog(0, 3); exp_rd("tog3_off", 1, 3, 0); exp_sig("cnt_tog3_off", K_CNT, 0); tick();

    // collision and dual distinct toggles
    tog(0, 5); tog(1, 5); exp_rd("coll5", 2, 5, 0); exp_sig("cnt_coll5", K_CNT, 0); tick();
    tog(0, 2); tog(1, 6);
    exp_rd("dual2", 0, 2, 1); exp_rd("dual6", 1, 6, 1); exp_sig("cnt_dual", K_CNT, 2); tick();
    tog(0, 0); tog(1, 3);
    exp_rd("set0", 0, 0, 1); exp_rd("set3", 1, 3, 1); exp_sig("cnt_set03", K_CNT, 4); tick();
    tog(1, 7); exp_rd("set7", 2, 7, 1); exp_sig("cnt_set7", K_CNT, 5); tick();

    // same-cycle read while toggling
    tog(0, 1);
    exp_rd("fwd_same_cycle", 1, 1, BYP);
    drain();
    exp_rd("fwd_next_cycle", 1, 1, 1); exp_sig("cnt_set1", K_CNT, 6); tick();

    // bulk clear with simultaneous toggle of id 4; entries 0,1,2,3,4,6,7 set afterwards
    clear_req = 1'b1; tog(0, 4);
    exp_rd("clr_tog4_applied", 0, 4, 1); exp_rd("clr_rd0_unswept", 1, 0, 1);
    exp_sig("clr_busy0", K_BUSY, 1); exp_sig("clr_ready0", K_RDY, 0);
    exp_sig("clr_done0", K_DONE, 0); exp_sig("clr_cnt0", K_CNT, 7);
    tick();
    clear_req = 1'b1; tog(0, 5);
    exp_rd("clr_rd0_swept", 0, 0, 0); exp_rd("clr_rd1_swept", 1, 1, 0);
    exp_rd("clr_rd7_unswept", 2, 7, 1); exp_sig("clr_busy1", K_BUSY, 1);
    exp_sig("clr_cnt1", K_CNT, 5);
    tick();
    clear_req = 1'b1; tog(1, 7);
    exp_rd("clr_rd7_kept", 0, 7, 1); exp_rd("clr_rd4_kept", 1, 4, 1);
    exp_rd("clr_rd3_swept", 2, 3, 0); exp_sig("clr_busy2", K_BUSY, 1);
    exp_sig("clr_cnt2", K_CNT, 3);
    tick();
    clear_req = 1'b1;
    exp_rd("clr_rd4_swept", 0, 4, 0); exp_rd("clr_rd5_dropped", 1, 5, 0);
    exp_sig("clr_busy3", K_BUSY, 1); exp_sig("clr_done3", K_DONE, 0);
    exp_sig("clr_cnt3", K_CNT, 2);
    tick();
    clear_req = 1'b1; tog(0, 5);
    exp_sig("done_pulse", K_DONE, 1); exp_sig("done_busy", K_BUSY, 0);
    exp_sig("done_ready", K_RDY, 0); exp_sig("done_cnt", K_CNT, 0);
    exp_rd("done_rd7", 0, 7, 0); exp_rd("done_rd6", 1, 6, 0);
    tick();
    exp_sig("idle_ready", K_RDY, 1); exp_sig("idle_done", K_DONE, 0);
    exp_sig("idle_no_resweep", K_BUSY, 0); exp_sig("idle_cnt", K_CNT, 0);
    exp_rd("idle_rd5_dropped", 2, 5, 0);
    tick();

    // async reset in the middle of a sweep
    tog(0, 6); tog(1, 7);
    exp_rd("ar_set6", 0, 6, 1); exp_rd("ar_set7", 1, 7, 1); exp_sig("ar_cnt_pre", K_CNT, 2);
    tick();
    clear_req = 1'b1;
    exp_sig("ar_busy0", K_BUSY, 1); exp_sig("ar_cnt0", K_CNT, 2);
    tick();
    exp_sig("ar_busy1", K_BUSY, 1); exp_rd("ar_rd6_unswept", 0, 6, 1);
    tick();
    #2;
    rst = 1'b0;
    exp_rd("ar_rd6", 0, 6, 0); exp_rd("ar_rd7", 1, 7, 0);
    exp_sig("ar_cnt", K_CNT, 0); exp_sig("ar_ready", K_RDY, 1);
    exp_sig("ar_busy", K_BUSY, 0); exp_sig("ar_done", K_DONE, 0);
    drain();
    @(negedge clk);
    rst = 1'b1;
    tog(0, 0); exp_rd("post_rst_tog0", 2, 0, 1); exp_sig("post_rst_cnt", K_CNT, 1); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
